// File: rtl/simple_memory_arbiter.sv
// Arbitrates one simple_memory between the instruction-fetch port (I) and the load/store port (D).
// A D write and a non-overlapping I read share a cycle; contended reads alternate round-robin.
module simple_memory_arbiter #(
  parameter int unsigned pWords = 32'd128
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwIReq,
  input  logic [31:0] iwIAddr,
  output logic        owIGnt,
  output logic        orIRvalid,
  output logic [31:0] owIRdata,
  input  logic        iwDReq,
  input  logic        iwDWe,
  input  logic [31:0] iwDAddr,
  input  logic [31:0] iwDWdata,
  input  logic [3:0]  iwDWstrb,
  output logic        owDGnt,
  output logic        orDRvalid,
  output logic [31:0] owDRdata,
  output logic        orDErr,
  output logic [31:0] owMemReadAddr,
  output logic [31:0] owMemWriteAddr,
  output logic [31:0] owMemWriteData,
  output logic [3:0]  owMemWstrb,
  input  logic [31:0] iwMemReadData
);

  localparam logic [32:0] cLastWord = 33'(pWords * 4 - 4);

  logic        wIInRange;
  logic        wDInRange;
  logic        wDRead;
  logic        wDWrite;
  logic [32:0] wIEnd;
  logic [32:0] wDEnd;
  logic [30:0] wIWordLo;
  logic [30:0] wIWordHi;
  logic [30:0] wDWordLo;
  logic [30:0] wDWordHi;
  logic        wOverlap;
  logic        wDReadGnt;
  logic        rLastRdD;
  logic        rIOutOfRange;
  logic        rDOutOfRange;

  // 33-bit compares so addresses near 2^32 cannot wrap into range
  assign wIInRange = ({1'b0, iwIAddr} <= cLastWord);
  assign wDInRange = ({1'b0, iwDAddr} <= cLastWord);
  assign wDRead    = iwDReq & ~iwDWe;
  assign wDWrite   = iwDReq & iwDWe;

  // Each 4-byte access touches at most two words; any shared word is a conflict
  assign wIEnd    = {1'b0, iwIAddr} + 33'd3;
  assign wDEnd    = {1'b0, iwDAddr} + 33'd3;
  assign wIWordLo = {1'b0, iwIAddr[31:2]};
  assign wIWordHi = wIEnd[32:2];
  assign wDWordLo = {1'b0, iwDAddr[31:2]};
  assign wDWordHi = wDEnd[32:2];
  assign wOverlap = (wIWordLo == wDWordLo) | (wIWordLo == wDWordHi) |
                    (wIWordHi == wDWordLo) | (wIWordHi == wDWordHi);

  always_comb begin
    owDGnt = 1'b0;
    owIGnt = 1'b0;
    if (wDWrite) begin
      owDGnt = 1'b1;
      owIGnt = iwIReq & ~wOverlap;
    end else if (wDRead && iwIReq) begin
      owDGnt = ~rLastRdD;
      owIGnt = rLastRdD;
    end else begin
      owDGnt = wDRead;
      owIGnt = iwIReq;
    end
  end

  assign wDReadGnt = owDGnt & wDRead;

  always_comb begin
    owMemReadAddr  = 32'd0;
    owMemWriteAddr = 32'd0;
    owMemWriteData = 32'd0;
    owMemWstrb     = 4'd0;
    if (owIGnt && wIInRange) begin
      owMemReadAddr = iwIAddr;
    end else if (wDReadGnt && wDInRange) begin
      owMemReadAddr = iwDAddr;
    end
    if (wDWrite) begin
      owMemWriteAddr = iwDAddr;
      owMemWriteData = iwDWdata;
      owMemWstrb     = wDInRange ? iwDWstrb : 4'd0;
    end
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      orIRvalid    <= 1'b0;
      orDRvalid    <= 1'b0;
      orDErr       <= 1'b0;
      rLastRdD     <= 1'b0;
      rIOutOfRange <= 1'b0;
      rDOutOfRange <= 1'b0;
    end else begin
      orIRvalid    <= owIGnt;
      orDRvalid    <= wDReadGnt;
      orDErr       <= owDGnt & ~wDInRange;
      rIOutOfRange <= owIGnt & ~wIInRange;
      rDOutOfRange <= wDReadGnt & ~wDInRange;
      if (wDReadGnt) begin
        rLastRdD <= 1'b1;
      end else if (owIGnt) begin
        rLastRdD <= 1'b0;
      end
    end
  end

  assign owIRdata = (orIRvalid && !rIOutOfRange) ? iwMemReadData : 32'd0;
  assign owDRdata = (orDRvalid && !rDOutOfRange) ? iwMemReadData : 32'd0;

endmodule

// File: tb/tb_simple_memory_arbiter.sv
// Self-checking bench for simple_memory_arbiter: directed table, hand sequences and
// randomized traffic against a byte-level reference model of arbitration and memory.
module tb_simple_memory_arbiter;

  localparam int unsigned pWords = 128;
  localparam longint cBytes = longint'(pWords) * 4;

  logic        iwClk;
  logic        iwnRst;
  logic        iwIReq;
  logic [31:0] iwIAddr;
  logic        owIGnt;
  logic        orIRvalid;
  logic [31:0] owIRdata;
  logic        iwDReq;
  logic        iwDWe;
  logic [31:0] iwDAddr;
  logic [31:0] iwDWdata;
  logic [3:0]  iwDWstrb;
  logic        owDGnt;
  logic        orDRvalid;
  logic [31:0] owDRdata;
  logic        orDErr;
  logic [31:0] owMemReadAddr;
  logic [31:0] owMemWriteAddr;
  logic [31:0] owMemWriteData;
  logic [3:0]  owMemWstrb;
  logic [31:0] iwMemReadData;

  int checks;
  int failures;

  simple_memory_arbiter #(.pWords(pWords)) dut (
    .iwClk(iwClk), .iwnRst(iwnRst),
    .iwIReq(iwIReq), .iwIAddr(iwIAddr), .owIGnt(owIGnt),
    .orIRvalid(orIRvalid), .owIRdata(owIRdata),
    .iwDReq(iwDReq), .iwDWe(iwDWe), .iwDAddr(iwDAddr),
    .iwDWdata(iwDWdata), .iwDWstrb(iwDWstrb), .owDGnt(owDGnt),
    .orDRvalid(orDRvalid), .owDRdata(owDRdata), .orDErr(orDErr),
    .owMemReadAddr(owMemReadAddr), .owMemWriteAddr(owMemWriteAddr),
    .owMemWriteData(owMemWriteData), .owMemWstrb(owMemWstrb),
    .iwMemReadData(iwMemReadData)
  );

  initial iwClk = 1'b0;
  always #5 iwClk = ~iwClk;

  // Behavioural simple_memory: byte-addressed, little-endian, registered read
  logic [7:0] mem [0:1023];

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[10'(addr + 32'(k))];
    return w;
  endfunction

  always @(posedge iwClk) begin
    iwMemReadData <= memWord(owMemReadAddr);
    for (int k = 0; k < 4; k++)
      if (owMemWstrb[k]) mem[10'(owMemWriteAddr + 32'(k))] <= owMemWriteData[8*k +: 8];
  end

  // Reference model state
  logic [7:0]  modelMem [0:1023];
  bit          mLastD;
  bit          eIV, eDV, eErr;
  logic [31:0] eIData, eDData;

  function automatic logic [7:0] initByte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic bit inRange(input logic [31:0] addr);
    return (longint'(addr) + 4) <= cBytes;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = modelMem[10'(addr + 32'(k))];
    return w;
  endfunction

  function automatic bit touchSameWord(input logic [31:0] a, input logic [31:0] b);
    bit hit;
    hit = 1'b0;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        if (((longint'(a) + x) / 4) == ((longint'(b) + y) / 4)) hit = 1'b1;
    return hit;
  endfunction

  typedef struct {
    bit          iReq;
    logic [31:0] iAddr;
    bit          dReq;
    bit          dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dWstrb;
    bit          expIGnt;
    bit          expDGnt;
    logic [31:0] expRdAddr;
    logic [3:0]  expWstrb;
  } vec_t;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check grants/mux mid-cycle, check responses after the edge
  task automatic applyStimulus(input vec_t v, input bit useTable);
    bit mI, mD, dRead, dWrite;
    logic [31:0] rdAddr, wrAddr, wrData;
    logic [3:0]  wstrb;
    @(negedge iwClk);
    iwIReq = v.iReq;   iwIAddr = v.iAddr;
    iwDReq = v.dReq;   iwDWe = v.dWe;     iwDAddr = v.dAddr;
    iwDWdata = v.dWdata; iwDWstrb = v.dWstrb;
    #1;
    dRead  = v.dReq && !v.dWe;
    dWrite = v.dReq && v.dWe;
    mI = 1'b0; mD = 1'b0;
    if (dWrite) begin
      mD = 1'b1;
      mI = v.iReq && !touchSameWord(v.iAddr, v.dAddr);
    end else if (dRead && v.iReq) begin
      if (mLastD) mI = 1'b1; else mD = 1'b1;
    end else begin
      mI = v.iReq;
      mD = dRead;
    end
    rdAddr = 32'd0;
    if (mI && inRange(v.iAddr)) rdAddr = v.iAddr;
    else if (mD && dRead && inRange(v.dAddr)) rdAddr = v.dAddr;
    wrAddr = dWrite ? v.dAddr : 32'd0;
    wrData = dWrite ? v.dWdata : 32'd0;
    wstrb  = (dWrite && inRange(v.dAddr)) ? v.dWstrb : 4'd0;
    checkOutput("IGnt", 32'(owIGnt), 32'(mI));
    checkOutput("DGnt", 32'(owDGnt), 32'(mD));
    checkOutput("MemReadAddr", owMemReadAddr, rdAddr);
    checkOutput("MemWriteAddr", owMemWriteAddr, wrAddr);
    checkOutput("MemWriteData", owMemWriteData, wrData);
    checkOutput("MemWstrb", 32'(owMemWstrb), 32'(wstrb));
    if (useTable) begin
      checkOutput("tblIGnt", 32'(owIGnt), 32'(v.expIGnt));
      checkOutput("tblDGnt", 32'(owDGnt), 32'(v.expDGnt));
      checkOutput("tblRdAddr", owMemReadAddr, v.expRdAddr);
      checkOutput("tblWstrb", 32'(owMemWstrb), 32'(v.expWstrb));
    end
    eIV    = mI;
    eIData = (mI && inRange(v.iAddr)) ? modelRead(v.iAddr) : 32'd0;
    eDV    = mD && dRead;
    eDData = (mD && dRead && inRange(v.dAddr)) ? modelRead(v.dAddr) : 32'd0;
    eErr   = mD && !inRange(v.dAddr);
    if (mD && dRead) mLastD = 1'b1;
    else if (mI) mLastD = 1'b0;
    if (dWrite && inRange(v.dAddr))
      for (int k = 0; k < 4; k++)
        if (v.dWstrb[k]) modelMem[10'(v.dAddr + 32'(k))] = v.dWdata[8*k +: 8];
    @(posedge iwClk);
    #1;
    checkOutput("IRvalid", 32'(orIRvalid), 32'(eIV));
    checkOutput("IRdata", owIRdata, eIData);
    checkOutput("DRvalid", 32'(orDRvalid), 32'(eDV));
    checkOutput("DRdata", owDRdata, eDData);
    checkOutput("DErr", 32'(orDErr), 32'(eErr));
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkVal(name, act, exp);
  endtask

  task automatic resetDut();
    @(negedge iwClk);
    iwnRst = 1'b0;
    iwIReq = 1'b0; iwIAddr = '0; iwDReq = 1'b0; iwDWe = 1'b0;
    iwDAddr = '0; iwDWdata = '0; iwDWstrb = '0;
    repeat (2) @(posedge iwClk);
    #1;
    checkOutput("rstIRvalid", 32'(orIRvalid), 32'd0);
    checkOutput("rstDRvalid", 32'(orDRvalid), 32'd0);
    checkOutput("rstDErr", 32'(orDErr), 32'd0);
    checkOutput("rstIRdata", owIRdata, 32'd0);
    checkOutput("rstDRdata", owDRdata, 32'd0);
    @(negedge iwClk);
    iwnRst = 1'b1;
    mLastD = 1'b0;
  endtask

  function automatic vec_t mk(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                              input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
    vec_t v;
    v = '{ir, ia, dr, we, da, wd, ws, 1'b0, 1'b0, 32'd0, 4'd0};
    return v;
  endfunction

  vec_t tbl [10];
  vec_t v;
  logic [31:0] da, ia;
  int r;

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = initByte(i);
      modelMem[i] = initByte(i);
    end
    iwnRst = 1'b0;
    iwIReq = 1'b0; iwIAddr = '0; iwDReq = 1'b0; iwDWe = 1'b0;
    iwDAddr = '0; iwDWdata = '0; iwDWstrb = '0;

    tbl[0] = '{1, 32'h000, 0, 0, 32'h000, 32'h0,          4'h0, 1, 0, 32'h000, 4'h0};
    tbl[1] = '{1, 32'h010, 1, 0, 32'h020, 32'h0,          4'h0, 0, 1, 32'h020, 4'h0};
    tbl[2] = '{1, 32'h010, 1, 0, 32'h020, 32'h0,          4'h0, 1, 0, 32'h010, 4'h0};
    tbl[3] = '{1, 32'h080, 1, 1, 32'h040, 32'hCAFEBABE,   4'hF, 1, 1, 32'h080, 4'hF};
    tbl[4] = '{1, 32'h042, 1, 1, 32'h040, 32'hDEADBEEF,   4'h3, 0, 1, 32'h000, 4'h3};
    tbl[5] = '{0, 32'h000, 1, 1, 32'h1FD, 32'h01020304,   4'hF, 0, 1, 32'h000, 4'h0};
    tbl[6] = '{0, 32'h000, 1, 0, 32'h200, 32'h0,          4'h0, 0, 1, 32'h000, 4'h0};
    tbl[7] = '{1, 32'h1FC, 0, 0, 32'h000, 32'h0,          4'h0, 1, 0, 32'h1FC, 4'h0};
    tbl[8] = '{1, 32'h0FD, 1, 1, 32'h100, 32'h99887766,   4'hF, 0, 1, 32'h000, 4'hF};
    tbl[9] = '{0, 32'h000, 0, 0, 32'h000, 32'h0,          4'h0, 0, 0, 32'h000, 4'h0};

    resetDut();
    for (int i = 0; i < 10; i++) applyStimulus(tbl[i], 1'b1);

    // I-only fetch stream at consecutive word addresses
    for (int i = 0; i < 3; i++) applyStimulus(mk(1, 32'(4 * i), 0, 0, 0, 0, 0), 1'b0);

    // Write beside an unrelated fetch, then fetch the written word
    applyStimulus(mk(1, 32'h80, 1, 1, 32'h40, 32'h11223344, 4'hF), 1'b0);
    applyStimulus(mk(1, 32'h40, 0, 0, 0, 0, 0), 1'b0);
    checkOutput("fetchAfterWrite", owIRdata, 32'h11223344);

    // Overlapping write and fetch: fetch must see the new bytes a cycle later
    applyStimulus(mk(1, 32'h42, 1, 1, 32'h40, 32'h55667788, 4'hF), 1'b0);
    checkOutput("overlapNoIRvalid", 32'(orIRvalid), 32'd0);
    applyStimulus(mk(1, 32'h42, 0, 0, 0, 0, 0), 1'b0);
    checkOutput("overlapNewBytes", {16'd0, owIRdata[15:0]}, 32'h00005566);

    // Out-of-range read and write on D
    applyStimulus(mk(0, 0, 1, 0, 32'h200, 0, 0), 1'b0);
    checkOutput("oorRvalid", 32'(orDRvalid), 32'd1);
    checkOutput("oorRdata", owDRdata, 32'd0);
    checkOutput("oorErr", 32'(orDErr), 32'd1);
    applyStimulus(mk(0, 0, 1, 1, 32'h1FD, 32'hFFFFFFFF, 4'hF), 1'b0);
    checkOutput("oorWrErr", 32'(orDErr), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      da = 32'h200 + 32'($urandom_range(0, 15));
      else if (r == 1) da = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      else             da = 32'($urandom_range(0, 511));
      r = $urandom_range(0, 9);
      if (r < 3)       ia = da + 32'($urandom_range(0, 7)) - 32'd3;
      else if (r == 3) ia = 32'h1FE + 32'($urandom_range(0, 4));
      else             ia = 32'($urandom_range(0, 511));
      v = mk($urandom_range(0, 3) != 0, ia, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             da, $urandom, 4'($urandom_range(0, 15)));
      applyStimulus(v, 1'b0);
    end

    // Reset during an outstanding fetch drops its rvalid
    @(negedge iwClk);
    iwIReq = 1'b1; iwIAddr = 32'h0; iwDReq = 1'b0; iwDWe = 1'b0;
    #1;
    checkOutput("preRstIGnt", 32'(owIGnt), 32'd1);
    #1;
    iwnRst = 1'b0;
    iwIReq = 1'b0;
    @(posedge iwClk);
    #1;
    checkOutput("midRstIRvalid", 32'(orIRvalid), 32'd0);
    @(posedge iwClk);
    #1;
    checkOutput("midRstIRvalid2", 32'(orIRvalid), 32'd0);
    @(negedge iwClk);
    iwnRst = 1'b1;
    mLastD = 1'b0;
    applyStimulus(mk(1, 32'h10, 1, 0, 32'h20, 0, 0), 1'b0);
    checkOutput("postRstDWins", 32'(orDRvalid), 32'd1);
    applyStimulus(mk(1, 32'h10, 1, 0, 32'h20, 0, 0), 1'b0);
    checkOutput("postRstIThen", 32'(orIRvalid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
